// File: rtl/coll_event_gen.sv
// Collision/button event generator: synchronises and debounces two raw levels, arbitrates
// them (bad first) and emits spaced 1-cycle pulses. Optional auto-repeat: AUTO_REPEAT_EN.
module coll_event_gen #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLDOFF_CYCLES  = 8,
    parameter int unsigned REPEAT_CYCLES   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic goodRaw,
    input  logic badRaw,
    output logic goodCollButton,
    output logic badCollButton,
    output logic busy,
    output logic evtDropped
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HoW = $clog2(HOLDOFF_CYCLES + 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || HOLDOFF_CYCLES < 1 || REPEAT_CYCLES < 1)
    begin : g_bad_cfg
        $error("coll_event_gen: illegal parameter value");
    end

    typedef enum logic [1:0] {StIdle, StEmit, StHoldoff} state_e;

    // Channel index 0 is good, 1 is bad.
    logic [1:0]             raw;
    logic [SYNC_STAGES-1:0] sync_q   [2];
    logic [DbW-1:0]         db_cnt_q [2];
    logic [DbW-1:0]         db_cnt_d [2];
    logic [1:0]             stable_q, stable_d;
    logic [1:0]             rise;
    logic [1:0]             pend_q, pend_d;
    logic [1:0]             take;
    logic                   drop_q, drop_d;
    logic                   rep_set;
    logic                   decide;

    state_e         state_q;
    logic [HoW-1:0] ho_cnt_q;
    logic           good_q, bad_q, busy_q;

    assign raw = {badRaw, goodRaw};

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            stable_d[c] = stable_q[c];
            db_cnt_d[c] = '0;
            rise[c]     = 1'b0;
            if (sync_q[c][SYNC_STAGES-1] != stable_q[c]) begin
                if (db_cnt_q[c] == DbW'(DEBOUNCE_CYCLES - 1)) begin
                    stable_d[c] = sync_q[c][SYNC_STAGES-1];
                    rise[c]     = sync_q[c][SYNC_STAGES-1];
                end else begin
                    db_cnt_d[c] = db_cnt_q[c] + DbW'(1);
                end
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RpW = $clog2(REPEAT_CYCLES + 1);
    logic [RpW-1:0] rep_q, rep_d;

    // Counts from the debounced press; a fresh press restarts the period.
    always_comb begin
        rep_d   = '0;
        rep_set = 1'b0;
        if (stable_q[0] && stable_d[0]) begin
            if (rep_q == RpW'(REPEAT_CYCLES - 1)) begin
                rep_set = 1'b1;
            end else begin
                rep_d = rep_q + RpW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`else
    assign rep_set = 1'b0;
`endif

    // The FSM consumes a pending event when idle or on the last holdoff cycle.
    always_comb begin
        decide = (state_q == StIdle) ||
                 (state_q == StHoldoff && ho_cnt_q == HoW'(HOLDOFF_CYCLES - 1));
        take[1] = decide & pend_q[1];
        take[0] = decide & pend_q[0] & ~pend_q[1];
        pend_d  = (pend_q & ~take) | rise | {1'b0, rep_set};
        drop_d  = drop_q | (|(rise & pend_q & ~take));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                sync_q[c]   <= '0;
                db_cnt_q[c] <= '0;
            end
            stable_q <= '0;
            pend_q   <= '0;
            drop_q   <= 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                sync_q[c]   <= {sync_q[c][SYNC_STAGES-2:0], raw[c]};
                db_cnt_q[c] <= db_cnt_d[c];
            end
            stable_q <= stable_d;
            pend_q   <= pend_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            ho_cnt_q <= '0;
            good_q   <= 1'b0;
            bad_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (|take) begin
                        state_q <= StEmit;
                        good_q  <= take[0];
                        bad_q   <= take[1];
                        busy_q  <= 1'b1;
                    end
                end
                StEmit: begin
                    state_q  <= StHoldoff;
                    ho_cnt_q <= '0;
                    good_q   <= 1'b0;
                    bad_q    <= 1'b0;
                    busy_q   <= 1'b1;
                end
                StHoldoff: begin
                    if (ho_cnt_q == HoW'(HOLDOFF_CYCLES - 1)) begin
                        state_q <= (|take) ? StEmit : StIdle;
                        good_q  <= take[0];
                        bad_q   <= take[1];
                        busy_q  <= |take;
                    end else begin
                        ho_cnt_q <= ho_cnt_q + HoW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    good_q  <= 1'b0;
                    bad_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign goodCollButton = good_q;
    assign badCollButton  = bad_q;
    assign busy           = busy_q;
    assign evtDropped     = drop_q;

endmodule

// File: tb/tb_coll_event_gen.sv
// Self-checking bench for coll_event_gen: directed vector tables, reset sequences and a
// randomized run against a timing-level reference model.
module tb_coll_event_gen;

    localparam int S = 2;
    localparam int D = 4;
    localparam int H = 8;
    localparam int R = 16;

    logic clk = 1'b0;
    logic rst;
    logic goodRaw;
    logic badRaw;
    logic goodCollButton;
    logic badCollButton;
    logic busy;
    logic evtDropped;

    int checks   = 0;
    int failures = 0;
    int t        = 0;

    coll_event_gen #(
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D),
        .HOLDOFF_CYCLES (H),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .goodRaw       (goodRaw),
        .badRaw        (badRaw),
        .goodCollButton(goodCollButton),
        .badCollButton (badCollButton),
        .busy          (busy),
        .evtDropped    (evtDropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic g;
        logic b;
        logic eg;
        logic eb;
        logic ebusy;
        logic edrop;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%b expected=%b", name, t, act, exp);
        end
    endtask

    task automatic step(input logic g, input logic b);
        goodRaw = g;
        badRaw  = b;
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        goodRaw = 1'b0;
        badRaw  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        t   = 0;
    endtask

    task automatic add(input logic g, input logic b, input logic eg, input logic eb,
                       input logic ebusy, input logic edrop);
        vec_t v;
        v.g = g; v.b = b; v.eg = eg; v.eb = eb; v.ebusy = ebusy; v.edrop = edrop;
        tbl.push_back(v);
    endtask

    task automatic run_table(input string name);
        do_reset();
        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].g, tbl[k].b);
            check({name, "_good"}, goodCollButton, tbl[k].eg);
            check({name, "_bad"}, badCollButton, tbl[k].eb);
            check({name, "_busy"}, busy, tbl[k].ebusy);
            check({name, "_drop"}, evtDropped, tbl[k].edrop);
        end
        tbl.delete();
    endtask

    function automatic logic in_busy(input int k, input int p);
        return (k >= p) && (k <= p + H);
    endfunction

    // Reference model: delay line, run-length debounce, pulse-spacing arbitration.
    logic [1:0] mhist[$];
    int         mrun[2];
    logic [1:0] mstab;
    logic [1:0] mpend;
    logic       mdrop;
    int         mlast;
    int         mrep;
    logic       exp_g, exp_b, exp_busy;

    task automatic model_reset();
        mhist.delete();
        for (int i = 0; i < S; i++) mhist.push_back(2'b00);
        mrun[0] = 0; mrun[1] = 0;
        mstab = '0; mpend = '0; mdrop = 1'b0;
        mlast = -1000; mrep = 0;
    endtask

    task automatic model_step(input logic g, input logic b);
        logic [1:0] v;
        logic [1:0] rose;
        logic [1:0] emit;
        logic       rep;
        logic       can;
        v    = mhist.pop_front();
        mhist.push_back({b, g});
        rose = '0;
        for (int c = 0; c < 2; c++) begin
            if (v[c] != mstab[c]) mrun[c]++;
            else mrun[c] = 0;
            if (mrun[c] == D) begin
                mstab[c] = v[c];
                mrun[c]  = 0;
                rose[c]  = v[c];
            end
        end
        rep = 1'b0;
`ifdef AUTO_REPEAT_EN
        if (mstab[0] && !rose[0]) begin
            mrep++;
            if (mrep == R) begin
                rep  = 1'b1;
                mrep = 0;
            end
        end else begin
            mrep = 0;
        end
`endif
        can     = (t - mlast) >= H + 1;
        emit[1] = can && mpend[1];
        emit[0] = can && mpend[0] && !mpend[1];
        for (int c = 0; c < 2; c++) begin
            if (rose[c] && mpend[c] && !emit[c]) mdrop = 1'b1;
            mpend[c] = (mpend[c] && !emit[c]) || rose[c] || (c == 0 && rep);
        end
        if (|emit) mlast = t;
        exp_g    = emit[0];
        exp_b    = emit[1];
        exp_busy = (t - mlast) <= H;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0d got=timeout expected=finish", t);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic g, b;
        int   dut_last;

        do_reset();
        check("reset_good", goodCollButton, 1'b0);
        check("reset_bad", badCollButton, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_drop", evtDropped, 1'b0);

        // Glitch of 3 cycles is filtered.
        for (int k = 1; k <= 20; k++) add(k <= 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_table("glitch");

        // Held press: single pulse at t=7 (repeats at 23 and 39 with auto-repeat).
        for (int k = 1; k <= 50; k++) begin
            logic eg, eb;
`ifdef AUTO_REPEAT_EN
            eg = (k == 7) || (k == 23) || (k == 39);
            eb = in_busy(k, 7) || in_busy(k, 23) || in_busy(k, 39);
`else
            eg = (k == 7);
            eb = in_busy(k, 7);
`endif
            add(k <= 40, 1'b0, eg, 1'b0, eb, 1'b0);
        end
        run_table("hold");

        // Simultaneous edges: bad first, good after holdoff.
        for (int k = 1; k <= 24; k++)
            add(1'b1, 1'b1, k == 16, k == 7, in_busy(k, 7) || in_busy(k, 16), 1'b0);
        run_table("simul");

        // Press, release, press: second stable edge at t=14 lands in holdoff.
        for (int k = 1; k <= 26; k++)
            add((k <= 4) || (k >= 9), 1'b0, (k == 7) || (k == 16), 1'b0,
                in_busy(k, 7) || in_busy(k, 16), 1'b0);
        run_table("repress");

        // Same good pattern with bad held: good still pending at t=14, so it drops.
        for (int k = 1; k <= 26; k++)
            add((k <= 4) || (k >= 9), 1'b1, k == 16, k == 7,
                in_busy(k, 7) || in_busy(k, 16), k >= 14);
        run_table("drop");

        // Reset in the middle of a pulse.
        do_reset();
        repeat (7) step(1'b1, 1'b1);
        check("rstpulse_pre_bad", badCollButton, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rstpulse_bad", badCollButton, 1'b0);
        check("rstpulse_busy", busy, 1'b0);

        // Reset during holdoff with good pending: nothing emerges afterwards.
        do_reset();
        repeat (11) step(1'b1, 1'b1);
        check("rsthold_pre_busy", busy, 1'b1);
        #2;
        rst     = 1'b1;
        goodRaw = 1'b0;
        badRaw  = 1'b0;
        #1;
        check("rsthold_good", goodCollButton, 1'b0);
        check("rsthold_bad", badCollButton, 1'b0);
        check("rsthold_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        t   = 0;
        for (int k = 1; k <= 30; k++) begin
            step(1'b0, 1'b0);
            check("after_rst_good", goodCollButton, 1'b0);
            check("after_rst_bad", badCollButton, 1'b0);
            check("after_rst_busy", busy, 1'b0);
        end

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        g        = 1'b0;
        b        = 1'b0;
        dut_last = -1000;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(4) == 0) g = ~g;
            if ($urandom_range(4) == 0) b = ~b;
            step(g, b);
            model_step(g, b);
            check("rnd_good", goodCollButton, exp_g);
            check("rnd_bad", badCollButton, exp_b);
            check("rnd_busy", busy, exp_busy);
            check("rnd_drop", evtDropped, mdrop);
            check("rnd_exclusive", goodCollButton & badCollButton, 1'b0);
            if (goodCollButton || badCollButton) begin
                if (dut_last > -1000) check("rnd_spacing", (t - dut_last) >= H + 1, 1'b1);
                dut_last = t;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
